// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the RV32 fetch sequencer
package rv_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // RV32 without compressed instructions needs word-aligned targets
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/rv_fetch_seq.sv
// rtl/rv_fetch_seq.sv - fetch FSM, PC owner and decode-side holding register
module rv_fetch_seq
    import rv_fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [WIDTH-1:0] dec_instr,
    output logic [WIDTH-1:0] dec_pc,
    output logic             fault,
    output logic [31:0]      fetch_count
);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pend_pc;
    logic             redir_bad;
    logic             handshake;

    assign redir_bad = redirect_valid && is_misaligned(redirect_pc[1:0]);
    assign handshake = dec_valid && dec_ready;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (redir_bad) begin
                    state_nxt = ST_HALT;
                end else if (redirect_valid) begin
                    state_nxt = ST_IDLE;
                end else if (run) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // a redirect with the ack in hand can re-issue at once; otherwise drain first
                if (redir_bad) begin
                    state_nxt = imem_ack ? ST_HALT : ST_DRAIN;
                end else if (redirect_valid) begin
                    state_nxt = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_nxt = (fault || redir_bad) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redir_bad) begin
                    state_nxt = ST_HALT;
                end else if (redirect_valid || dec_ready) begin
                    state_nxt = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == ST_FETCH) || (state == ST_DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            pend_pc     <= '0;
            dec_valid   <= 1'b0;
            dec_instr   <= '0;
            dec_pc      <= '0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redir_bad) begin
                        fault <= 1'b1;
                    end else if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                end
                ST_FETCH: begin
                    if (redir_bad) begin
                        fault <= 1'b1;
                    end else if (redirect_valid) begin
                        if (imem_ack) begin
                            pc <= redirect_pc;
                        end else begin
                            pend_pc <= redirect_pc;
                        end
                    end else if (imem_ack) begin
                        dec_instr <= imem_rdata;
                        dec_pc    <= pc;
                        pc        <= pc + WIDTH'(INSTR_BYTES);
                        dec_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // latest redirect wins, even when it lands in the ack cycle
                    if (redir_bad) begin
                        fault <= 1'b1;
                    end else if (!fault) begin
                        if (redirect_valid) begin
                            pend_pc <= redirect_pc;
                        end
                        if (imem_ack) begin
                            pc <= redirect_valid ? redirect_pc : pend_pc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        fetch_count <= fetch_count + 32'd1;
                    end
                    if (redir_bad) begin
                        fault     <= 1'b1;
                        dec_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        dec_valid <= 1'b0;
                        pc        <= redirect_pc;
                    end else if (dec_ready) begin
                        dec_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    dec_valid <= 1'b0;
                end
                default: begin
                    dec_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rv_fetch_seq.md
Name: rv_fetch_seq

Overview:
Fetch sequencer for the RV32 front end. It drives instruction-memory reads and holds the returned instruction word. It presents that word with its PC to the field-decode register over a valid/ready handshake. It also owns the PC, handles redirects (branch/jump/trap) and flags misaligned redirect targets.

Parameters:
WIDTH, 32, data/address width; instruction word width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  reset, asynchronous, active-high.
run  input  1  start/continue fetching; sampled in IDLE and at HOLD exit.
imem_req  output  1  read request; held high until imem_ack.
imem_addr  output  WIDTH  read address (= pc register); stable while imem_req high.
imem_ack  input  1  read complete; imem_rdata valid this cycle only.
imem_rdata  input  WIDTH  instruction word.
redirect_valid  input  1  load new PC (one-cycle pulse or level; each high cycle is a redirect).
redirect_pc  input  WIDTH  redirect target.
dec_valid  output  1  dec_instr/dec_pc valid.
dec_ready  input  1  decoder accepts the word this cycle.
dec_instr  output  WIDTH  held instruction word.
dec_pc  output  WIDTH  address the word was fetched from.
fault  output  1  sticky misaligned-redirect flag.
fetch_count  output  32  count of completed dec handshakes.

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, pend_pc=0, dec_valid=0, dec_instr=0, dec_pc=0, fault=0, fetch_count=0. imem_req=0 (decoded from state).
- All outputs come from registers. No combinational path from any input to any output.
- imem_req=1 exactly in FETCH and DRAIN. imem_addr=pc at all times.
- One outstanding request maximum. Protocol rule: once imem_req rises, the request is never withdrawn or re-addressed before imem_ack.
- States and transitions:
  - IDLE: run=1 -> FETCH. redirect_valid loads pc<=redirect_pc and stays in IDLE.
  - FETCH with imem_ack and no redirect: dec_instr<=imem_rdata, dec_pc<=pc, pc<=pc+4 (mod 2^WIDTH), dec_valid<=1 -> HOLD. Latency: ack in cycle N gives dec_valid in cycle N+1.
  - FETCH with redirect and imem_ack in the same cycle: response discarded, pc<=redirect_pc -> FETCH. imem_req stays high with the new address next cycle.
  - FETCH with redirect and no ack: pend_pc<=redirect_pc -> DRAIN.
  - DRAIN: keep requesting the old pc until imem_ack. On ack, discard the data, pc<=pend_pc -> FETCH. A further redirect in DRAIN overwrites pend_pc (latest wins), including in the ack cycle.
  - HOLD: dec_valid=1. dec_instr and dec_pc are stable until handshake.
    - On dec_valid&&dec_ready: dec_valid<=0, fetch_count+1 (wraps), then run=1 -> FETCH, run=0 -> IDLE.
    - Redirect in HOLD: dec_valid<=0, pc<=redirect_pc -> FETCH (IDLE if run=0). If dec_ready is high in the same cycle, the handshake completes and counts; the redirect still applies.
  - HALT: imem_req=0, dec_valid=0. Exit only by rst.
- Misaligned redirect: redirect_valid with redirect_pc[1:0]!=0, in any state except HALT.
  - fault<=1 (sticky), dec_valid<=0.
  - From FETCH/DRAIN: go via DRAIN to complete the outstanding access, then HALT.
  - From other states: go to HALT directly.
- run deassertion has no effect in FETCH/DRAIN; the current fetch completes into HOLD.

Decomposition:
- Package rv_fetch_pkg: state encoding (IDLE, FETCH, DRAIN, HOLD, HALT), INSTR_BYTES=4, default RESET_PC.
- No sub-module. FSM, PC and counter are inline in one module.
- The decode field splitter stays a separate existing block, fed by dec_instr under dec_valid.

Test Plan:
- Reset, run=1, memory acks 1 cycle after each req with rdata=addr^32'hA5A5_A5A5, dec_ready=1 -> imem_addr sequence 0,4,8,C. dec_pc matches each word. fetch_count=4 after 4 handshakes.
- Hold dec_ready=0 for 5 cycles in HOLD -> dec_valid, dec_instr and dec_pc stable. No imem_req. After dec_ready=1, next req at pc+4.
- Redirect to 32'h100 while FETCH waits 3 cycles for ack -> address stays old until ack. Data discarded, dec_valid never rises for it. Next imem_addr=32'h100.
- Redirect to 32'h200 in the same cycle as imem_ack -> response dropped, next imem_addr=32'h200. Redirect in HOLD with dec_ready=1 -> fetch_count increments and next address is the redirect target.
- Redirect to 32'h102 -> fault=1, outstanding access drained, imem_req=0 thereafter. Only rst clears fault.
- Assert rst asynchronously mid-FETCH (between clock edges) -> imem_req, dec_valid and fault low immediately, pc=RESET_PC. Fetch resumes from RESET_PC after release.
